bbox_cmp_alu: RTL and testbench

Parametrised successor to the bitmap compare ALU. It consumes one W-column x H-row glyph bitmap as two independent valid/ready streams: columns left-to-right and rows top-to-bottom. It finds the bounding box of set pixels, then reports left/right/top/bottom empty margins plus horizontal and vertical 2x-scale flags against programmable thresholds. It sits between the bitmap fetch unit and the glyph placement/scaler stage.

---
 rtl/bbox_cmp_alu.sv | 208 ++++++++++++++++++++
 tb/tb_bbox_cmp_alu.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_cmp_alu.sv
// Glyph bounding-box margin finder fed by independent column and row streams.
// Reports empty margins and 2x-scale hints once both streams are complete.
`timescale 1ns/1ps
module bbox_cmp_alu #(
  parameter int W = 24,
  parameter int H = 64,
  parameter int HTHRESH = 12,
  parameter int VTHRESH = 32,
  localparam int CW = $clog2(W + 1),
  localparam int RW = $clog2(H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          col_valid,
  output logic          col_ready,
  input  logic [H-1:0]  col_data,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [W-1:0]  row_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic [CW-1:0] lshift,
  output logic [CW-1:0] right_empty,
  output logic [RW-1:0] top_empty,
  output logic [RW-1:0] dshift,
  output logic          scale_h,
  output logic          scale_v,
  output logic          blank
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CALC,
    DONE
  } state_e;

  localparam logic [CW-1:0] W_MAX  = CW'(W);
  localparam logic [CW-1:0] W_LAST = CW'(W - 1);
  localparam logic [RW-1:0] H_MAX  = RW'(H);
  localparam logic [RW-1:0] H_LAST = RW'(H - 1);

  state_e state_q, state_d;

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [CW-1:0] col_first_q, col_first_d;
  logic [CW-1:0] col_last_q, col_last_d;
  logic          col_seen_q, col_seen_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [RW-1:0] row_first_q, row_first_d;
  logic [RW-1:0] row_last_q, row_last_d;
  logic          row_seen_q, row_seen_d;

  logic [CW-1:0] lshift_q, lshift_d;
  logic [CW-1:0] right_q, right_d;
  logic [RW-1:0] top_q, top_d;
  logic [RW-1:0] dshift_q, dshift_d;
  logic          scale_h_q, scale_h_d;
  logic          scale_v_q, scale_v_d;
  logic          blank_q, blank_d;

  logic          col_acc;
  logic          row_acc;
  logic          has_px;
  logic [CW-1:0] rgap;
  logic [RW-1:0] bgap;
  logic [CW:0]   hsum;
  logic [RW:0]   vsum;

  assign col_ready = (state_q == SCAN) && (col_cnt_q < W_MAX);
  assign row_ready = (state_q == SCAN) && (row_cnt_q < H_MAX);
  assign col_acc   = col_valid && col_ready;
  assign row_acc   = row_valid && row_ready;

  // One-sided streams carry no usable box, so both must have seen a pixel.
  assign has_px = col_seen_q && row_seen_q;
  assign rgap   = W_LAST - col_last_q;
  assign bgap   = H_LAST - row_last_q;
  assign hsum   = {1'b0, col_first_q} + {1'b0, rgap};
  assign vsum   = {1'b0, row_first_q} + {1'b0, bgap};

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    col_first_d = col_first_q;
    col_last_d  = col_last_q;
    col_seen_d  = col_seen_q;
    row_cnt_d   = row_cnt_q;
    row_first_d = row_first_q;
    row_last_d  = row_last_q;
    row_seen_d  = row_seen_q;
    lshift_d    = lshift_q;
    right_d     = right_q;
    top_d       = top_q;
    dshift_d    = dshift_q;
    scale_h_d   = scale_h_q;
    scale_v_d   = scale_v_q;
    blank_d     = blank_q;

    if (start) begin
      state_d     = SCAN;
      col_cnt_d   = '0;
      col_first_d = '0;
      col_last_d  = '0;
      col_seen_d  = 1'b0;
      row_cnt_d   = '0;
      row_first_d = '0;
      row_last_d  = '0;
      row_seen_d  = 1'b0;
      lshift_d    = '0;
      right_d     = '0;
      top_d       = '0;
      dshift_d    = '0;
      scale_h_d   = 1'b0;
      scale_v_d   = 1'b0;
      blank_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SCAN: begin
          if (col_acc) begin
            col_cnt_d = col_cnt_q + CW'(1);
            if (|col_data) begin
              if (!col_seen_q) col_first_d = col_cnt_q;
              col_last_d = col_cnt_q;
              col_seen_d = 1'b1;
            end
          end
          if (row_acc) begin
            row_cnt_d = row_cnt_q + RW'(1);
            if (|row_data) begin
              if (!row_seen_q) row_first_d = row_cnt_q;
              row_last_d = row_cnt_q;
              row_seen_d = 1'b1;
            end
          end
          if (col_cnt_q == W_MAX && row_cnt_q == H_MAX)
            state_d = CALC;
        end
        CALC: begin
          blank_d   = !has_px;
          lshift_d  = has_px ? col_first_q : '0;
          right_d   = has_px ? rgap : '0;
          top_d     = has_px ? row_first_q : '0;
          dshift_d  = has_px ? bgap : '0;
          scale_h_d = has_px && (int'(hsum) >= HTHRESH);
          scale_v_d = has_px && (int'(vsum) >= VTHRESH);
          state_d   = DONE;
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      col_first_q <= '0;
      col_last_q  <= '0;
      col_seen_q  <= 1'b0;
      row_cnt_q   <= '0;
      row_first_q <= '0;
      row_last_q  <= '0;
      row_seen_q  <= 1'b0;
      lshift_q    <= '0;
      right_q     <= '0;
      top_q       <= '0;
      dshift_q    <= '0;
      scale_h_q   <= 1'b0;
      scale_v_q   <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      col_first_q <= col_first_d;
      col_last_q  <= col_last_d;
      col_seen_q  <= col_seen_d;
      row_cnt_q   <= row_cnt_d;
      row_first_q <= row_first_d;
      row_last_q  <= row_last_d;
      row_seen_q  <= row_seen_d;
      lshift_q    <= lshift_d;
      right_q     <= right_d;
      top_q       <= top_d;
      dshift_q    <= dshift_d;
      scale_h_q   <= scale_h_d;
      scale_v_q   <= scale_v_d;
      blank_q     <= blank_d;
    end
  end

  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign lshift      = lshift_q;
  assign right_empty = right_q;
  assign top_empty   = top_q;
  assign dshift      = dshift_q;
  assign scale_h     = scale_h_q;
  assign scale_v     = scale_v_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_bbox_cmp_alu.sv
// Directed bench for bbox_cmp_alu at W=24, H=64.
// Each scenario task drives its bitmap and checks hand-computed results.
`timescale 1ns/1ps
module tb_bbox_cmp_alu;

  localparam int W  = 24;
  localparam int H  = 64;
  localparam int CW = 5;
  localparam int RW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          col_valid;
  logic          col_ready;
  logic [H-1:0]  col_data;
  logic          row_valid;
  logic          row_ready;
  logic [W-1:0]  row_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic [CW-1:0] lshift;
  logic [CW-1:0] right_empty;
  logic [RW-1:0] top_empty;
  logic [RW-1:0] dshift;
  logic          scale_h;
  logic          scale_v;
  logic          blank;

  int vecs = 0;
  int errs = 0;

  logic [H-1:0] cols [W];
  logic [W-1:0] rows [H];

  bbox_cmp_alu #(
    .W(W), .H(H), .HTHRESH(12), .VTHRESH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .lshift(lshift), .right_empty(right_empty),
    .top_empty(top_empty), .dshift(dshift),
    .scale_h(scale_h), .scale_v(scale_v), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic clear_bm();
    for (int i = 0; i < W; i++) cols[i] = '0;
    for (int j = 0; j < H; j++) rows[j] = '0;
  endtask

  task automatic set_px(input int c, input int r);
    cols[c][r] = 1'b1;
    rows[r][c] = 1'b1;
  endtask

  task automatic fill_bm();
    for (int i = 0; i < W; i++) cols[i] = '1;
    for (int j = 0; j < H; j++) rows[j] = '1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_cols(input int n, input int gap);
    int to;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gap > 0 && i > 0) begin
        col_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      col_valid = 1'b1;
      col_data  = cols[i];
      to = 0;
      while (!col_ready && to < 300) begin
        @(negedge clk);
        to++;
      end
      vecs++;
      if (to >= 300) begin
        errs++;
        $display("FAIL col_beat%0d ready got 0 exp 1", i);
      end
    end
    @(negedge clk);
    col_valid = 1'b0;
    col_data  = '0;
  endtask

  task automatic send_rows(input int n, input int gap);
    int to;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gap > 0 && i > 0) begin
        row_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      row_valid = 1'b1;
      row_data  = rows[i];
      to = 0;
      while (!row_ready && to < 300) begin
        @(negedge clk);
        to++;
      end
      vecs++;
      if (to >= 300) begin
        errs++;
        $display("FAIL row_beat%0d ready got 0 exp 1", i);
      end
    end
    @(negedge clk);
    row_valid = 1'b0;
    row_data  = '0;
  endtask

  task automatic run_bm();
    do_start();
    fork
      send_cols(W, 0);
      send_rows(H, 0);
    join
  endtask

  task automatic wait_res();
    int to = 0;
    while (!res_valid && to < 400) begin
      @(negedge clk);
      to++;
    end
    vecs++;
    if (!res_valid) begin
      errs++;
      $display("FAIL res_valid_wait got 0 exp 1");
    end
  endtask

  task automatic ack();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", busy); end
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    vecs++; if (col_ready !== 1'b0) begin errs++; $display("FAIL rst_col_ready got %b exp 0", col_ready); end
    vecs++; if (row_ready !== 1'b0) begin errs++; $display("FAIL rst_row_ready got %b exp 0", row_ready); end
    vecs++; if ({lshift, right_empty, top_empty, dshift} !== '0) begin errs++; $display("FAIL rst_margins got %h exp 0", {lshift, right_empty, top_empty, dshift}); end
    vecs++; if ({scale_h, scale_v, blank} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b exp 000", {scale_h, scale_v, blank}); end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_pixel();
    clear_bm();
    set_px(5, 10);
    run_bm();
    wait_res();
    vecs++; if (lshift !== 5'd5) begin errs++; $display("FAIL px_lshift got %0d exp 5", lshift); end
    vecs++; if (right_empty !== 5'd18) begin errs++; $display("FAIL px_right got %0d exp 18", right_empty); end
    vecs++; if (top_empty !== 7'd10) begin errs++; $display("FAIL px_top got %0d exp 10", top_empty); end
    vecs++; if (dshift !== 7'd53) begin errs++; $display("FAIL px_dshift got %0d exp 53", dshift); end
    vecs++; if ({scale_h, scale_v, blank} !== 3'b110) begin errs++; $display("FAIL px_flags got %b exp 110", {scale_h, scale_v, blank}); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL px_busy got %b exp 1", busy); end
    ack();
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL px_ack_valid got %b exp 0", res_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL px_ack_busy got %b exp 0", busy); end
    vecs++; if (lshift !== 5'd5) begin errs++; $display("FAIL px_ack_hold got %0d exp 5", lshift); end
  endtask

  task automatic test_back_to_back();
    fill_bm();
    run_bm();
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL b2b_lat0 got %b exp 0", res_valid); end
    @(negedge clk);
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL b2b_lat1 got %b exp 0", res_valid); end
    @(negedge clk);
    vecs++; if (res_valid !== 1'b1) begin errs++; $display("FAIL b2b_lat2 got %b exp 1", res_valid); end
    vecs++; if ({lshift, right_empty, top_empty, dshift} !== '0) begin errs++; $display("FAIL b2b_margins got %h exp 0", {lshift, right_empty, top_empty, dshift}); end
    vecs++; if ({scale_h, scale_v, blank} !== 3'b000) begin errs++; $display("FAIL b2b_flags got %b exp 000", {scale_h, scale_v, blank}); end
    ack();
  endtask

  task automatic test_blank();
    clear_bm();
    run_bm();
    wait_res();
    vecs++; if (blank !== 1'b1) begin errs++; $display("FAIL blank_flag got %b exp 1", blank); end
    vecs++; if ({lshift, right_empty, top_empty, dshift} !== '0) begin errs++; $display("FAIL blank_margins got %h exp 0", {lshift, right_empty, top_empty, dshift}); end
    vecs++; if ({scale_h, scale_v} !== 2'b00) begin errs++; $display("FAIL blank_scale got %b exp 00", {scale_h, scale_v}); end
    ack();
    clear_bm();
    cols[3][4] = 1'b1;
    run_bm();
    wait_res();
    vecs++; if (blank !== 1'b1) begin errs++; $display("FAIL incons_blank got %b exp 1", blank); end
    vecs++; if ({lshift, right_empty, scale_h, scale_v} !== '0) begin errs++; $display("FAIL incons_fields got %h exp 0", {lshift, right_empty, scale_h, scale_v}); end
    ack();
  endtask

  task automatic test_scale();
    clear_bm();
    for (int c = 5; c <= 17; c++) set_px(c, 0);
    run_bm();
    wait_res();
    vecs++; if ({lshift, right_empty} !== {5'd5, 5'd6}) begin errs++; $display("FAIL sh11_margins got %0d/%0d exp 5/6", lshift, right_empty); end
    vecs++; if ({scale_h, scale_v, blank} !== 3'b010) begin errs++; $display("FAIL sh11_flags got %b exp 010", {scale_h, scale_v, blank}); end
    ack();
    clear_bm();
    for (int c = 6; c <= 17; c++) set_px(c, 0);
    run_bm();
    wait_res();
    vecs++; if ({lshift, right_empty} !== {5'd6, 5'd6}) begin errs++; $display("FAIL sh12_margins got %0d/%0d exp 6/6", lshift, right_empty); end
    vecs++; if (scale_h !== 1'b1) begin errs++; $display("FAIL sh12_scale_h got %b exp 1", scale_h); end
    ack();
    clear_bm();
    for (int r = 16; r <= 47; r++) set_px(0, r);
    run_bm();
    wait_res();
    vecs++; if ({top_empty, dshift} !== {7'd16, 7'd16}) begin errs++; $display("FAIL sv32_margins got %0d/%0d exp 16/16", top_empty, dshift); end
    vecs++; if (scale_v !== 1'b1) begin errs++; $display("FAIL sv32_scale_v got %b exp 1", scale_v); end
    ack();
    set_px(0, 48);
    run_bm();
    wait_res();
    vecs++; if ({top_empty, dshift} !== {7'd16, 7'd15}) begin errs++; $display("FAIL sv31_margins got %0d/%0d exp 16/15", top_empty, dshift); end
    vecs++; if (scale_v !== 1'b0) begin errs++; $display("FAIL sv31_scale_v got %b exp 0", scale_v); end
    ack();
  endtask

  task automatic test_gaps_hold();
    clear_bm();
    set_px(3, 20);
    set_px(15, 40);
    do_start();
    fork
      begin
        send_rows(H, 0);
        row_valid = 1'b1;
        row_data  = '1;
        repeat (5) begin
          @(negedge clk);
          vecs++;
          if (row_ready !== 1'b0) begin errs++; $display("FAIL gap_row_extra got ready %b exp 0", row_ready); end
        end
        row_valid = 1'b0;
        row_data  = '0;
      end
      send_cols(W, 3);
    join
    col_valid = 1'b1;
    col_data  = '1;
    @(negedge clk);
    vecs++; if (col_ready !== 1'b0) begin errs++; $display("FAIL gap_col_extra got ready %b exp 0", col_ready); end
    col_valid = 1'b0;
    col_data  = '0;
    wait_res();
    vecs++; if ({lshift, right_empty} !== {5'd3, 5'd8}) begin errs++; $display("FAIL gap_h got %0d/%0d exp 3/8", lshift, right_empty); end
    vecs++; if ({top_empty, dshift} !== {7'd20, 7'd23}) begin errs++; $display("FAIL gap_v got %0d/%0d exp 20/23", top_empty, dshift); end
    vecs++; if ({scale_h, scale_v, blank} !== 3'b010) begin errs++; $display("FAIL gap_flags got %b exp 010", {scale_h, scale_v, blank}); end
    repeat (5) begin
      @(negedge clk);
      vecs++;
      if ({res_valid, lshift, dshift, scale_v} !== {1'b1, 5'd3, 7'd23, 1'b1}) begin
        errs++;
        $display("FAIL gap_hold got v%b l%0d d%0d exp v1 l3 d23", res_valid, lshift, dshift);
      end
    end
    ack();
    vecs++; if ({busy, res_valid} !== 2'b00) begin errs++; $display("FAIL gap_idle got %b exp 00", {busy, res_valid}); end
  endtask

  task automatic test_restart();
    fill_bm();
    do_start();
    fork
      send_cols(10, 0);
      send_rows(7, 0);
    join
    start     = 1'b1;
    col_valid = 1'b1;
    col_data  = '1;
    row_valid = 1'b1;
    row_data  = '1;
    @(negedge clk);
    start     = 1'b0;
    col_valid = 1'b0;
    col_data  = '0;
    row_valid = 1'b0;
    row_data  = '0;
    vecs++; if ({busy, col_ready, row_ready} !== 3'b111) begin errs++; $display("FAIL rs_scan got %b exp 111", {busy, col_ready, row_ready}); end
    clear_bm();
    set_px(7, 2);
    fork
      send_cols(W, 0);
      send_rows(H, 0);
    join
    wait_res();
    vecs++; if ({lshift, right_empty} !== {5'd7, 5'd16}) begin errs++; $display("FAIL rs_h got %0d/%0d exp 7/16", lshift, right_empty); end
    vecs++; if ({top_empty, dshift} !== {7'd2, 7'd61}) begin errs++; $display("FAIL rs_v got %0d/%0d exp 2/61", top_empty, dshift); end
    vecs++; if ({scale_h, scale_v, blank} !== 3'b110) begin errs++; $display("FAIL rs_flags got %b exp 110", {scale_h, scale_v, blank}); end
    ack();
  endtask

  task automatic test_reset_mid_scan();
    fill_bm();
    do_start();
    send_cols(5, 0);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    vecs++; if ({busy, col_ready, row_ready, res_valid} !== 4'b0000) begin errs++; $display("FAIL mrst_ctl got %b exp 0000", {busy, col_ready, row_ready, res_valid}); end
    vecs++; if ({lshift, right_empty, top_empty, dshift} !== '0) begin errs++; $display("FAIL mrst_margins got %h exp 0", {lshift, right_empty, top_empty, dshift}); end
    vecs++; if ({scale_h, scale_v, blank} !== 3'b000) begin errs++; $display("FAIL mrst_flags got %b exp 000", {scale_h, scale_v, blank}); end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mrst_after got %b exp 0", busy); end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    col_valid = 1'b0;
    col_data  = '0;
    row_valid = 1'b0;
    row_data  = '0;
    res_ready = 1'b0;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_blank();
    test_scale();
    test_gaps_hold();
    test_restart();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
